ws281x_pixel_fifo: RTL and testbench

Pixel buffer that sits directly upstream of the WS281x serial driver. It accepts 24-bit GRB pixel writes from the register/DMA side and applies a global brightness scale in a one-cycle write pipeline. Scaled pixels are buffered in a FIFO. The FIFO head is presented to the driver on its data_available / green / red / blue / data_rd interface.

---
 rtl/ws281x_pixel_fifo_if.sv | 34 +++
 rtl/ws281x_pixel_fifo.sv | 150 +++++++++++++++
 tb/tb_ws281x_pixel_fifo.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws281x_pixel_fifo_if.sv
// Pixel handshake between the write/DMA side, the pixel FIFO and the WS281x driver.
// The master side drives writes and pops; the slave side (the FIFO) returns the head.
interface ws281x_pixel_fifo_if;
  logic        wr_en;
  logic [23:0] wr_data;
  logic        wr_full;
  logic        data_available;
  logic [7:0]  green_out;
  logic [7:0]  red_out;
  logic [7:0]  blue_out;
  logic        data_rd;

  modport master (
    output wr_en,
    output wr_data,
    input  wr_full,
    input  data_available,
    input  green_out,
    input  red_out,
    input  blue_out,
    output data_rd
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output wr_full,
    output data_available,
    output green_out,
    output red_out,
    output blue_out,
    input  data_rd
  );
endinterface

// File: rtl/ws281x_pixel_fifo.sv
// Brightness-scaling pixel buffer feeding the WS281x serial driver.
// One-cycle scaling stage in front of a DEPTH-entry FIFO whose head is shown combinationally.
module ws281x_pixel_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_flush,
  input  logic [7:0]            cfg_brightness,
  input  logic                  cfg_err_clr,
  ws281x_pixel_fifo_if.slave    pix,
  output logic [AW:0]           fifo_level,
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam logic [AW+1:0] DepthOcc = (AW+2)'(DEPTH);

  logic [23:0] mem_q [DEPTH];
  logic [23:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          stg_vld_q, stg_vld_d;
  logic [23:0]   stg_data_q, stg_data_d;
  logic          ovf_err_q, ovf_err_d;
  logic          udf_err_q, udf_err_d;

  logic [AW+1:0] occupancy;
  logic          full;
  logic          empty;
  logic          wr_accept;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          udf_set;
  logic [23:0]   head;
  logic [23:0]   scaled;

  // (c * (b + 1)) >> 8 keeps 255 as identity and 0 as black.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, b} + 17'd1);
    return 8'(prod >> 8);
  endfunction

  always_comb begin
    scaled = {scale_chan(pix.wr_data[23:16], cfg_brightness),
              scale_chan(pix.wr_data[15:8],  cfg_brightness),
              scale_chan(pix.wr_data[7:0],   cfg_brightness)};
  end

  // The staged pixel counts against capacity so the stage-to-FIFO write can never overflow.
  always_comb begin
    occupancy = {1'b0, count_q} + {{(AW+1){1'b0}}, stg_vld_q};
    full      = (occupancy >= DepthOcc);
    empty     = (count_q == '0);
  end

  always_comb begin
    wr_accept = pix.wr_en && !full && !cfg_flush;
    push      = stg_vld_q && !cfg_flush;
    pop       = pix.data_rd && !empty && !cfg_flush;
    ovf_set   = pix.wr_en && full && !cfg_flush;
    udf_set   = pix.data_rd && empty && !cfg_flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    stg_vld_d  = stg_vld_q;
    stg_data_d = stg_data_q;

    if (cfg_flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      stg_vld_d = 1'b0;
    end else begin
      stg_vld_d = wr_accept;
      if (wr_accept) begin
        stg_data_d = scaled;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (AW+1)'(1);
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = stg_data_q;
    end
  end

  // Set wins over a same-cycle clear.
  always_comb begin
    ovf_err_d = (ovf_err_q && !cfg_err_clr) || ovf_set;
    udf_err_d = (udf_err_q && !cfg_err_clr) || udf_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      ovf_err_q  <= 1'b0;
      udf_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      ovf_err_q  <= ovf_err_d;
      udf_err_q  <= udf_err_d;
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head               = mem_q[rd_ptr_q];
    pix.data_available = !empty;
    pix.wr_full        = full;
    pix.green_out      = empty ? 8'd0 : head[23:16];
    pix.red_out        = empty ? 8'd0 : head[15:8];
    pix.blue_out       = empty ? 8'd0 : head[7:0];
    fifo_level         = count_q;
    ovf_err            = ovf_err_q;
    udf_err            = udf_err_q;
  end

endmodule

// File: tb/tb_ws281x_pixel_fifo.sv
// Self-checking bench for ws281x_pixel_fifo: vector table plus scoreboard of expected
// head pixels, with hand-written sequences for full, underflow, flush and reset.
module tb_ws281x_pixel_fifo;

  localparam int Depth = 16;

  logic       clk;
  logic       reset_n;
  logic       cfg_flush;
  logic [7:0] cfg_brightness;
  logic       cfg_err_clr;
  logic [4:0] fifo_level;
  logic       ovf_err;
  logic       udf_err;

  ws281x_pixel_fifo_if pix ();

  ws281x_pixel_fifo #(
    .DEPTH (Depth),
    .AW    (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_flush      (cfg_flush),
    .cfg_brightness (cfg_brightness),
    .cfg_err_clr    (cfg_err_clr),
    .pix            (pix.slave),
    .fifo_level     (fifo_level),
    .ovf_err        (ovf_err),
    .udf_err        (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] px;
    logic [7:0]  br;
    logic [23:0] exp_grb;
  } vec_t;

  vec_t        vecs [5];
  logic [23:0] exp_q [$];
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_chan(input logic [7:0] c, input logic [7:0] b);
    int v;
    v = (int'(c) * (int'(b) + 1)) / 256;
    return v[7:0];
  endfunction

  function automatic logic [23:0] exp_px(input logic [23:0] p, input logic [7:0] b);
    return {exp_chan(p[23:16], b), exp_chan(p[15:8], b), exp_chan(p[7:0], b)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [23:0] head_now();
    return {pix.green_out, pix.red_out, pix.blue_out};
  endfunction

  task automatic write_px(input logic [23:0] px, input logic [7:0] br);
    pix.wr_en      = 1'b1;
    pix.wr_data    = px;
    cfg_brightness = br;
    if (exp_q.size() < Depth) exp_q.push_back(exp_px(px, br));
    tick();
    pix.wr_en = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [23:0] want;
    want = (exp_q.size() != 0) ? exp_q[0] : 24'd0;
    check({name, " avail"}, 32'(pix.data_available), 32'(exp_q.size() != 0));
    check({name, " head"}, 32'(head_now()), 32'(want));
    pix.data_rd = 1'b1;
    tick();
    pix.data_rd = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic wr_pop(input logic [23:0] px, input string name);
    logic accept;
    accept = (exp_q.size() < Depth);
    check({name, " head"}, 32'(head_now()), 32'(exp_q[0]));
    pix.wr_en      = 1'b1;
    pix.wr_data    = px;
    pix.data_rd    = 1'b1;
    cfg_brightness = 8'd255;
    tick();
    pix.wr_en   = 1'b0;
    pix.data_rd = 1'b0;
    void'(exp_q.pop_front());
    if (accept) exp_q.push_back(px);
  endtask

  task automatic err_clr_pulse();
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{px: 24'h123456, br: 8'd255, exp_grb: 24'h123456};
    vecs[1] = '{px: 24'hFF8001, br: 8'd127, exp_grb: 24'h7F4000};
    vecs[2] = '{px: 24'hFF8001, br: 8'd0,   exp_grb: 24'h000000};
    vecs[3] = '{px: 24'hA0B0C0, br: 8'd63,  exp_grb: 24'h282C30};
    vecs[4] = '{px: 24'hFFFFFF, br: 8'd254, exp_grb: 24'hFEFEFE};

    reset_n        = 1'b0;
    cfg_flush      = 1'b0;
    cfg_brightness = 8'd255;
    cfg_err_clr    = 1'b0;
    pix.wr_en      = 1'b0;
    pix.wr_data    = '0;
    pix.data_rd    = 1'b0;
    tick();
    tick();
    check("reset avail", 32'(pix.data_available), 0);
    check("reset full", 32'(pix.wr_full), 0);
    check("reset level", 32'(fifo_level), 0);
    check("reset errs", 32'({ovf_err, udf_err}), 0);
    check("reset colour", 32'(head_now()), 0);
    reset_n = 1'b1;
    tick();

    // Latency: write at edge N, data visible after edge N+1.
    write_px(24'h123456, 8'd255);
    check("lat n+1 avail", 32'(pix.data_available), 0);
    tick();
    check("lat n+2 avail", 32'(pix.data_available), 1);
    check("lat level", 32'(fifo_level), 1);
    pop_check("lat pop");
    check("lat empty", 32'(pix.data_available), 0);
    check("lat level0", 32'(fifo_level), 0);

    foreach (vecs[i]) begin
      write_px(vecs[i].px, vecs[i].br);
      tick();
      check($sformatf("vec%0d grb", i), 32'(head_now()), 32'(vecs[i].exp_grb));
      check($sformatf("vec%0d level", i), 32'(fifo_level), 1);
      pop_check($sformatf("vec%0d", i));
      check($sformatf("vec%0d empty", i), 32'(pix.data_available), 0);
    end

    // Seventeen back-to-back writes; the last must be dropped.
    for (int i = 0; i < 17; i++) begin
      if (i == 15) check("fill full@15", 32'(pix.wr_full), 0);
      if (i == 16) begin
        check("fill full@16", 32'(pix.wr_full), 1);
        check("fill ovf pre", 32'(ovf_err), 0);
      end
      write_px({8'(i), 8'(i * 3 + 1), 8'(i * 7 + 2)}, 8'd255);
    end
    check("fill ovf", 32'(ovf_err), 1);
    tick();
    check("fill level", 32'(fifo_level), 16);
    check("fill full", 32'(pix.wr_full), 1);
    err_clr_pulse();
    check("ovf clr", 32'(ovf_err), 0);

    pop_check("full pop");
    check("full drop", 32'(pix.wr_full), 0);
    check("full level15", 32'(fifo_level), 15);
    for (int i = 0; i < 4; i++) begin
      wr_pop({8'hC0, 8'(i), 8'h5A}, $sformatf("wrpop%0d", i));
    end
    tick();
    check("wrpop level", 32'(fifo_level), 15);
    write_px(24'hDEAD01, 8'd255);
    tick();
    check("refill level", 32'(fifo_level), 16);
    check("refill full", 32'(pix.wr_full), 1);
    check("refill ovf", 32'(ovf_err), 0);
    for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i));
    check("drain avail", 32'(pix.data_available), 0);
    check("drain level", 32'(fifo_level), 0);

    // Underflow and sticky-flag priority.
    pix.data_rd = 1'b1;
    tick();
    pix.data_rd = 1'b0;
    check("udf set", 32'(udf_err), 1);
    check("udf level", 32'(fifo_level), 0);
    write_px(24'hABCDEF, 8'd255);
    tick();
    pop_check("udf ptr");
    err_clr_pulse();
    check("udf clr", 32'(udf_err), 0);
    pix.data_rd = 1'b1;
    cfg_err_clr = 1'b1;
    tick();
    pix.data_rd = 1'b0;
    cfg_err_clr = 1'b0;
    check("udf set wins", 32'(udf_err), 1);
    err_clr_pulse();
    check("udf clr2", 32'(udf_err), 0);

    // Flush beats a same-cycle write.
    for (int i = 0; i < 5; i++) write_px({8'h11, 8'(i), 8'h22}, 8'd255);
    tick();
    check("flush pre level", 32'(fifo_level), 5);
    cfg_flush   = 1'b1;
    pix.wr_en   = 1'b1;
    pix.wr_data = 24'h777777;
    tick();
    cfg_flush = 1'b0;
    pix.wr_en = 1'b0;
    exp_q.delete();
    check("flush level", 32'(fifo_level), 0);
    check("flush avail", 32'(pix.data_available), 0);
    check("flush ovf", 32'(ovf_err), 0);
    tick();
    check("flush no stage", 32'(fifo_level), 0);
    write_px(24'h314159, 8'd255);
    tick();
    pop_check("post flush");

    // Asynchronous reset mid-stream.
    pix.data_rd = 1'b1;
    tick();
    pix.data_rd = 1'b0;
    for (int i = 0; i < 3; i++) write_px({8'h99, 8'(i), 8'h33}, 8'd255);
    tick();
    check("mid level", 32'(fifo_level), 3);
    check("mid udf", 32'(udf_err), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async avail", 32'(pix.data_available), 0);
    check("async level", 32'(fifo_level), 0);
    check("async errs", 32'({ovf_err, udf_err}), 0);
    check("async colour", 32'(head_now()), 0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
